// File: rtl/n101_dlm_bank_pkg.sv
// Shared power-state encodings and sizing helpers
// for the banked DLM controller.
package n101_dlm_bank_pkg;

    localparam logic [2:0] ACTIVE = 3'd0;
    localparam logic [2:0] LS     = 3'd1;
    localparam logic [2:0] DS     = 3'd2;
    localparam logic [2:0] SD     = 3'd3;
    localparam logic [2:0] WAKE   = 3'd4;

    function automatic int bw_of(input int n);
        int b;
        b = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                b = i + 1;
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/n101_dlm_bank_if.sv
// DLM command/response channel between the bus slave
// and the banked RAM controller.
interface n101_dlm_bank_if #(
    parameter int DW = 32,
    parameter int AW = 14,
    parameter int MW = DW / 8
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_read;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [MW-1:0] cmd_wmask;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;

    modport master (
        output cmd_valid, cmd_read, cmd_addr,
        output cmd_wdata, cmd_wmask, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  cmd_valid, cmd_read, cmd_addr,
        input  cmd_wdata, cmd_wmask, rsp_ready,
        output cmd_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/n101_dlm_pwr_fsm.sv
// Idle-driven power sequencer: ACTIVE/LS/DS/SD/WAKE
// plus the RAM low-power pin decode.
module n101_dlm_pwr_fsm
    import n101_dlm_bank_pkg::*;
#(
    parameter int LS_IDLE = 16,
    parameter int DS_IDLE = 256,
    parameter int WAKE_DS = 4,
    parameter int WAKE_SD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    input  logic       rsp_valid,
    input  logic       sd_req,
    output logic       active,
    output logic       ls,
    output logic       ds,
    output logic       sd,
    output logic [2:0] state
);
    localparam int CW = $clog2(DS_IDLE + 1);
    localparam int WM = (WAKE_SD > WAKE_DS) ? WAKE_SD : WAKE_DS;
    localparam int WW = $clog2(WM + 1);

    logic [CW-1:0] idle_cnt;
    logic [CW-1:0] idle_inc;
    logic [WW-1:0] wake_cnt;
    logic [WW-1:0] wake_d;
    logic [2:0]    state_d;
    logic          run_q;
    logic          idle;
    logic          hit_ls;
    logic          hit_ds;

    assign idle     = !cmd_valid && !rsp_valid;
    assign idle_inc = (idle_cnt == CW'(DS_IDLE)) ?
                      idle_cnt : idle_cnt + 1'b1;
    assign hit_ls   = (LS_IDLE != 0) && idle &&
                      (idle_inc >= CW'(LS_IDLE));
    assign hit_ds   = idle && (idle_inc >= CW'(DS_IDLE));

    always_comb begin
        state_d = state;
        wake_d  = wake_cnt;
        if (sd_req) begin
            state_d = SD;
        end else begin
            case (state)
                ACTIVE: begin
                    if (hit_ls) state_d = LS;
                end
                LS: begin
                    if (cmd_valid) begin
                        state_d = WAKE;
                        wake_d  = '0;
                    end else if (hit_ds) begin
                        state_d = DS;
                    end
                end
                DS: begin
                    if (cmd_valid) begin
                        state_d = WAKE;
                        wake_d  = WW'(WAKE_DS - 1);
                    end
                end
                SD: begin
                    state_d = WAKE;
                    wake_d  = WW'(WAKE_SD - 1);
                end
                WAKE: begin
                    if (wake_cnt == '0) state_d = ACTIVE;
                    else wake_d = wake_cnt - 1'b1;
                end
                default: state_d = ACTIVE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ACTIVE;
            wake_cnt <= '0;
            idle_cnt <= '0;
            run_q    <= 1'b0;
        end else begin
            state    <= state_d;
            wake_cnt <= wake_d;
            run_q    <= 1'b1;
            // sleep timing restarts from zero after every wake
            if (!idle || state == SD || state == WAKE) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_inc;
            end
        end
    end

    assign active = run_q && (state == ACTIVE);
    assign ls     = (state == LS);
    assign ds     = (state == DS);
    assign sd     = (state == SD);
endmodule

// File: rtl/n101_gnrl_ram.sv
// Single-port byte-masked RAM with write-first output
// and low-power pins that block access while asserted.
module n101_gnrl_ram #(
    parameter int DP = 8192,
    parameter int DW = 32,
    parameter int MW = DW / 8,
    parameter int AW = 13
) (
    input  logic          clk,
    input  logic          cs,
    input  logic          we,
    input  logic [MW-1:0] wem,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    input  logic          ls,
    input  logic          ds,
    input  logic          sd
);
    logic [DW-1:0] mem [DP];
    logic [DW-1:0] merged;
    logic          en;

    assign en = cs && !(ls || ds || sd);

    always_comb begin
        merged = mem[addr];
        for (int i = 0; i < MW; i++) begin
            if (wem[i]) begin
                merged[i*8 +: 8] = din[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= merged;
                dout      <= merged;
            end else begin
                dout      <= mem[addr];
            end
        end
    end
endmodule

// File: rtl/n101_dlm_bank_ctrl.sv
// Banked DLM RAM controller: address interleave, stallable
// read response with hold register, and power sequencing.
module n101_dlm_bank_ctrl
    import n101_dlm_bank_pkg::*;
#(
    parameter int DW      = 32,
    parameter int MW      = DW / 8,
    parameter int AW      = 14,
    parameter int NBANK   = 2,
    parameter int LS_IDLE = 16,
    parameter int DS_IDLE = 256,
    parameter int WAKE_DS = 4,
    parameter int WAKE_SD = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    n101_dlm_bank_if.slave    bus,
    input  logic              sd_req,
    output logic [2:0]        pwr_state
);
    localparam int BW = bw_of(NBANK);
    localparam int SW = (BW > 0) ? BW : 1;
    localparam int RW = AW - BW;

    logic             active;
    logic             ram_ls;
    logic             ram_ds;
    logic             ram_sd;
    logic             cmd_ready;
    logic             acc;
    logic [SW-1:0]    bank_sel;
    logic [RW-1:0]    row;
    logic [NBANK-1:0] bank_cs;
    logic [DW-1:0]    bank_dout [NBANK];

    logic             rsp_valid;
    logic [SW-1:0]    sel_q;
    logic             hold_vld;
    logic [DW-1:0]    hold;
    logic [DW-1:0]    dout_sel;

    n101_dlm_pwr_fsm #(
        .LS_IDLE (LS_IDLE),
        .DS_IDLE (DS_IDLE),
        .WAKE_DS (WAKE_DS),
        .WAKE_SD (WAKE_SD)
    ) u_pwr (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (bus.cmd_valid),
        .rsp_valid (rsp_valid),
        .sd_req    (sd_req),
        .active    (active),
        .ls        (ram_ls),
        .ds        (ram_ds),
        .sd        (ram_sd),
        .state     (pwr_state)
    );

    assign cmd_ready = active && !sd_req &&
                       (!bus.cmd_read || !rsp_valid ||
                        bus.rsp_ready);
    assign acc       = bus.cmd_valid && cmd_ready;
    assign bank_sel  = (NBANK == 1) ? '0 :
                       bus.cmd_addr[SW-1:0];
    assign row       = bus.cmd_addr[AW-1:BW];

    for (genvar b = 0; b < NBANK; b++) begin : g_bank
        assign bank_cs[b] = acc && (bank_sel == SW'(b));

        n101_gnrl_ram #(
            .DP (2 ** RW),
            .DW (DW),
            .MW (MW),
            .AW (RW)
        ) u_ram (
            .clk  (clk),
            .cs   (bank_cs[b]),
            .we   (!bus.cmd_read),
            .wem  (bus.cmd_wmask),
            .addr (row),
            .din  (bus.cmd_wdata),
            .dout (bank_dout[b]),
            .ls   (ram_ls),
            .ds   (ram_ds),
            .sd   (ram_sd)
        );
    end

    assign dout_sel = bank_dout[sel_q];

    // an unconsumed first-cycle response is parked so later
    // writes or a shutdown cannot disturb the bank output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            sel_q     <= '0;
            hold_vld  <= 1'b0;
            hold      <= '0;
        end else if (acc && bus.cmd_read) begin
            rsp_valid <= 1'b1;
            sel_q     <= bank_sel;
            hold_vld  <= 1'b0;
        end else if (rsp_valid && bus.rsp_ready) begin
            rsp_valid <= 1'b0;
            hold_vld  <= 1'b0;
        end else if (rsp_valid && !hold_vld) begin
            hold      <= dout_sel;
            hold_vld  <= 1'b1;
        end
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_rdata = !rsp_valid ? '0 :
                           hold_vld   ? hold : dout_sel;
endmodule

// File: tb/tb_n101_dlm_bank_ctrl.sv
// Directed bench for the banked DLM controller.
module tb_n101_dlm_bank_ctrl;
    import n101_dlm_bank_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sd_req = 1'b0;
    logic [2:0] pwr_state;
    int         total = 0;
    int         bad = 0;

    n101_dlm_bank_if #(.DW(32), .AW(14), .MW(4)) bus();

    n101_dlm_bank_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .sd_req    (sd_req),
        .pwr_state (pwr_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [63:0] obs,
                         input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [13:0] a,
                      input logic [31:0] d,
                      input logic [3:0]  m);
        bus.cmd_valid = 1'b1;
        bus.cmd_read  = 1'b0;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        bus.cmd_wmask = m;
        #1 check("wr_rdy", bus.cmd_ready, 1);
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic rd(input logic [13:0] a,
                      input logic [31:0] e,
                      input string tag);
        bus.cmd_valid = 1'b1;
        bus.cmd_read  = 1'b1;
        bus.cmd_addr  = a;
        bus.rsp_ready = 1'b1;
        #1 check({tag, "_rdy"}, bus.cmd_ready, 1);
        tick();
        bus.cmd_valid = 1'b0;
        #1;
        check({tag, "_vld"}, bus.rsp_valid, 1);
        check(tag, bus.rsp_rdata, e);
        tick();
        check({tag, "_done"}, bus.rsp_valid, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_read  = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.cmd_wmask = '0;
        bus.rsp_ready = 1'b0;

        // reset state, no RAM access while held in reset
        #12;
        check("rst_rdy", bus.cmd_ready, 0);
        check("rst_vld", bus.rsp_valid, 0);
        check("rst_data", bus.rsp_rdata, 0);
        check("rst_pwr", pwr_state, ACTIVE);
        bus.cmd_valid = 1'b1;
        #1 check("rst_cs", dut.bank_cs, 0);
        bus.cmd_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        check("post_rst_rdy", bus.cmd_ready, 1);

        // write/read addr 5: bank 1 only
        bus.cmd_valid = 1'b1;
        bus.cmd_read  = 1'b0;
        bus.cmd_addr  = 14'd5;
        bus.cmd_wdata = 32'hDEADBEEF;
        bus.cmd_wmask = 4'hF;
        #1 check("w5_cs", dut.bank_cs, 2'b10);
        tick();
        bus.cmd_read  = 1'b1;
        bus.rsp_ready = 1'b1;
        #1 check("r5_cs", dut.bank_cs, 2'b10);
        tick();
        bus.cmd_valid = 1'b0;
        #1;
        check("r5_vld", bus.rsp_valid, 1);
        check("r5_data", bus.rsp_rdata, 32'hDEADBEEF);
        check("r5_idle_cs", dut.bank_cs, 0);
        tick();
        check("r5_done", bus.rsp_valid, 0);

        // byte-masked write
        wr(14'd6, 32'hFFFFFFFF, 4'hF);
        wr(14'd6, 32'h11223344, 4'b0101);
        rd(14'd6, 32'hFF22FF44, "mask");

        // stalled response survives a write to the same bank
        wr(14'd2, 32'hA5A5A5A5, 4'hF);
        bus.cmd_valid = 1'b1;
        bus.cmd_read  = 1'b1;
        bus.cmd_addr  = 14'd2;
        bus.rsp_ready = 1'b0;
        tick();
        bus.cmd_read  = 1'b0;
        bus.cmd_wdata = 32'h0;
        bus.cmd_wmask = 4'hF;
        #1;
        check("stall_wr_rdy", bus.cmd_ready, 1);
        check("stall_d0", bus.rsp_rdata, 32'hA5A5A5A5);
        tick();
        bus.cmd_read = 1'b1;
        bus.cmd_addr = 14'd3;
        #1;
        check("stall_rd_rdy1", bus.cmd_ready, 0);
        check("stall_d1", bus.rsp_rdata, 32'hA5A5A5A5);
        tick();
        check("stall_rd_rdy2", bus.cmd_ready, 0);
        check("stall_d2", bus.rsp_rdata, 32'hA5A5A5A5);
        tick();
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        #1 check("stall_vld", bus.rsp_valid, 1);
        tick();
        check("stall_one_hs", bus.rsp_valid, 0);
        rd(14'd2, 32'h0, "stall_new");

        // light sleep after 16 idle cycles
        tick(15);
        check("ls_pre", pwr_state, ACTIVE);
        tick();
        check("ls_state", pwr_state, LS);
        check("ls_pin", dut.ram_ls, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_read  = 1'b0;
        bus.cmd_addr  = 14'd4;
        #1 check("ls_rdy0", bus.cmd_ready, 0);
        tick();
        check("ls_wake", pwr_state, WAKE);
        check("ls_rdy1", bus.cmd_ready, 0);
        tick();
        check("ls_rdy2", bus.cmd_ready, 1);
        tick();
        bus.cmd_valid = 1'b0;

        // deep sleep after 256 idle cycles
        tick(255);
        check("ds_pre", pwr_state, LS);
        tick();
        check("ds_state", pwr_state, DS);
        bus.cmd_valid = 1'b1;
        #1 check("ds_rdy0", bus.cmd_ready, 0);
        tick(4);
        check("ds_wake", pwr_state, WAKE);
        check("ds_rdy4", bus.cmd_ready, 0);
        tick();
        check("ds_rdy5", bus.cmd_ready, 1);
        tick();
        bus.cmd_valid = 1'b0;

        // shutdown pulse during back-to-back reads
        wr(14'd8, 32'h08080808, 4'hF);
        wr(14'd9, 32'h09090909, 4'hF);
        bus.cmd_valid = 1'b1;
        bus.cmd_read  = 1'b1;
        bus.cmd_addr  = 14'd8;
        bus.rsp_ready = 1'b1;
        tick();
        bus.cmd_addr = 14'd9;
        #1;
        check("b2b_rdy", bus.cmd_ready, 1);
        check("b2b_d0", bus.rsp_rdata, 32'h08080808);
        tick();
        bus.cmd_addr  = 14'd8;
        bus.rsp_ready = 1'b0;
        sd_req        = 1'b1;
        #1;
        check("sd_rdy", bus.cmd_ready, 0);
        check("sd_d1a", bus.rsp_rdata, 32'h09090909);
        tick();
        check("sd_state", pwr_state, SD);
        check("sd_vld", bus.rsp_valid, 1);
        check("sd_d1b", bus.rsp_rdata, 32'h09090909);
        tick();
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        tick();
        check("sd_hs", bus.rsp_valid, 0);
        check("sd_hold", pwr_state, SD);
        sd_req = 1'b0;
        tick();
        check("sd_wake", pwr_state, WAKE);
        bus.cmd_valid = 1'b1;
        bus.cmd_read  = 1'b1;
        bus.cmd_addr  = 14'd8;
        tick(7);
        check("sdw_rdy7", bus.cmd_ready, 0);
        tick();
        check("sdw_rdy8", bus.cmd_ready, 1);
        tick();
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        #1;
        check("sdw_vld", bus.rsp_valid, 1);
        check("sdw_data", bus.rsp_rdata, 32'h08080808);

        // asynchronous reset drops the pending response
        rst_n = 1'b0;
        #1;
        check("arst_vld", bus.rsp_valid, 0);
        check("arst_data", bus.rsp_rdata, 0);
        check("arst_rdy", bus.cmd_ready, 0);
        tick();
        rst_n = 1'b1;
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/n101_dlm_bank_ctrl.md
# n101_dlm_bank_ctrl

Parametrised, banked successor to the single-array DLM RAM wrapper. It accepts valid/ready word requests from the DLM bus slave and interleaves them across `NBANK` instances of `n101_gnrl_ram`. It returns read data through a stallable response channel. It also sequences the RAM low-power pins (`ls`/`ds`/`sd`) from its own idle counters rather than leaving them to the subsystem. It sits between the DLM bus slave port and the RAM macros in the n101 subsystem.

## Interface
Parameters:
- `DW`, 32: data width in bits; must be a multiple of 8.
- `MW`, `DW/8`: byte write-mask width.
- `AW`, 14: word-address width.
- `NBANK`, 2: number of banks; a power of two, ≥1. `BW = log2(NBANK)`.
- `LS_IDLE`, 16: idle cycles before entering light sleep. 0 disables auto-sleep.
- `DS_IDLE`, 256: idle cycles before entering deep sleep. Must be greater than `LS_IDLE`.
- `WAKE_DS`, 4: wake cycles from deep sleep.
- `WAKE_SD`, 8: wake cycles from shutdown.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: request valid.
- `cmd_ready` out 1: request accepted when high together with `cmd_valid`.
- `cmd_read` in 1: 1 = read, 0 = write.
- `cmd_addr` in AW: word address.
- `cmd_wdata` in DW: write data.
- `cmd_wmask` in MW: byte enables, writes only.
- `rsp_valid` out 1: read data valid.
- `rsp_ready` in 1: response consumer ready.
- `rsp_rdata` out DW: read data.
- `sd_req` in 1: shutdown request; level-sensitive.
- `pwr_state` out 3: current power-FSM state encoding.

## Operation
- Bank select is `cmd_addr[BW-1:0]`. Row is `cmd_addr[AW-1:BW]`, so each bank has depth `2^(AW-BW)`. When NBANK=1 the full address is the row.
- On acceptance, exactly one bank sees `cs=1`.
  - A write drives `we=1`, `wem=cmd_wmask` and `din=cmd_wdata`.
  - A read drives `we=0`.
  - Writes produce no response.
- Accept rule: `cmd_ready = (state==ACTIVE) && (!cmd_read || !rsp_valid || rsp_ready)`.
  - Writes proceed under a stalled response.
  - A second read waits until the response slot frees.
- Response hold:
  - In the first `rsp_valid` cycle, `rsp_rdata` comes from the selected bank `dout`; the bank select is registered at accept.
  - If `rsp_ready=0` in that cycle, the data is captured into a hold register.
  - `rsp_rdata` then comes from the hold register until the handshake completes, so later writes to the same bank cannot disturb it.
- Power FSM states and transitions:
  - ACTIVE → LS when the idle counter reaches `LS_IDLE`.
  - LS → DS when the idle counter reaches `DS_IDLE`.
  - LS → WAKE (1 cycle) on `cmd_valid`.
  - DS → WAKE (`WAKE_DS` cycles) on `cmd_valid`.
  - Any state → SD on `sd_req=1`.
  - SD → WAKE (`WAKE_SD` cycles) when `sd_req` falls.
  - WAKE → ACTIVE when its counter reaches 0.
- Pin mapping: `ls=1` in LS, `ds=1` in DS, `sd=1` in SD, all 0 otherwise, broadcast to all banks.
- The idle counter:
  - counts cycles in which `cmd_valid=0` and `rsp_valid=0`;
  - clears on any activity;
  - saturates at `DS_IDLE`.
- A pending `rsp_valid` blocks entry to LS, DS and SD only through the idle counter. When `sd_req` arrives with `rsp_valid=1`, the response is first moved into the hold register; it stays valid and is delivered in SD.
- RAM contents after SD are undefined; the block does not track this.

## Timing
- Reset values: `cmd_ready=0`, `rsp_valid=0`, `rsp_rdata=0`, `pwr_state=ACTIVE`, counters 0, hold register 0.
  - `cmd_ready` may rise in the first cycle after reset deassertion.
- Read latency: accept at cycle N gives `rsp_valid=1` at N+1.
- Throughput: back-to-back reads at one per cycle while `rsp_ready=1`. Writes are one per cycle regardless.
- Wake from LS: `cmd_valid` at N → WAKE at N+1 → `cmd_ready=1` at N+2.
- Wake from DS: first accept at N+1+`WAKE_DS`.
- Same-cycle `cmd_valid` and idle-threshold: the command wins, the counter clears and no sleep is entered.
- `sd_req` and `cmd_valid` in the same cycle: SD wins; the command is not accepted.
- Asynchronous reset mid-read drops the response. No RAM access is issued while `rst_n=0`.

## Structure
- Package `n101_dlm_bank_pkg`:
  - power-state localparams ACTIVE=0, LS=1, DS=2, SD=3, WAKE=4;
  - the `BW` computation function.
- Sub-module `n101_dlm_pwr_fsm`: owns the idle counter, wake counter and state register, and outputs `ls`/`ds`/`sd` and `active`.
- Banks are a generate loop of `n101_gnrl_ram` instances.

## Test plan
- Write 0xDEADBEEF to addr 5 with mask 0xF, then read addr 5 → `rsp_valid` at +1 with 0xDEADBEEF; bank 1 `cs` pulses, bank 0 stays idle.
- Masked write: write 0x11223344 with mask 0b0101 over 0xFFFFFFFF → read returns 0xFF22FF44.
- Read addr 2 with `rsp_ready=0` for 3 cycles while writing 0 to addr 2 → `rsp_rdata` stays at the old value and `cmd_ready` stays low for a second read; release gives one handshake.
- Idle 16 cycles → `pwr_state`=LS and `ls=1`; `cmd_valid` → accepted 2 cycles later.
- Idle 256 cycles → DS; then `cmd_valid` → accepted after 5 cycles.
- `sd_req` pulse during back-to-back reads → outstanding response delivered, SD for the pulse duration, `WAKE_SD` cycles, then normal accepts; `rst_n` asserted mid-read clears `rsp_valid` immediately.
